pixel_mixer: RTL and testbench
==============================

# pixel_mixer

Downstream consumer of the background and sprite pixel FIFOs in the PPU. Pulls one pixel per cycle from the background FIFO, discards the SCX fine-scroll pixels at line start, and merges the aligned sprite pixel using the sprite's priority bit. It then maps the result through BGP/OBP0/OBP1 and drives registered 2-bit shades plus an X coordinate to the LCD/framebuffer writer. It also tracks the 160-pixel line and signals line completion to the PPU mode controller.

## Interface
Parameters:
- X_MAX, 160, visible pixels per line

Ports:
- clk_in  input  1  system clock; the only clock
- rst_in  input  1  reset, asynchronous, active-low
- line_start_in  input  1  one-cycle pulse at mode-3 entry; starts a new line
- SCX_in  input  8  scroll X; only [2:0] used, latched on line_start_in
- BGP_in / OBP0_in / OBP1_in  input  8 each  DMG palettes, sampled live at mix time
- bg_win_ena_in  input  1  LCDC.0; 0 forces background colour 0
- sprite_detected_in  input  1  sprite fetch in progress; stalls reads
- bg_rd_en_out  output  1  read request to background FIFO
- bg_pixel_in  input  2  background colour index
- bg_valid_in  input  1  bg_pixel_in valid; arrives exactly 1 cycle after an accepted bg_rd_en_out
- sprite_pixel_in  input  2  sprite colour index aligned with bg_valid_in
- sprite_valid_in  input  1  sprite pixel present this cycle
- sprite_palette_in  input  1  0 = OBP0, 1 = OBP1
- sprite_priority_in  input  1  1 = sprite behind non-zero background
- pixel_out  output  2  final shade
- pixel_valid_out  output  1  pixel_out/X_out valid
- X_out  output  8  screen X of pixel_out, 0..X_MAX-1
- line_done_out  output  1  one-cycle pulse, line complete

## Operation
- States: IDLE, DISCARD, RUN, DONE. Reset → IDLE.
- line_start_in, from any state, does the following:
  - latches disc = SCX_in[2:0]
  - clears the issue counter (9 bits) and the X counter
  - moves to DISCARD if disc ≠ 0, else to RUN
  - aborts any line in progress; a bg_valid_in in flight from the aborted line is dropped.
- bg_rd_en_out = (state ∈ {DISCARD, RUN}) && !sprite_detected_in && (issued < disc + X_MAX). The issue counter increments on each cycle bg_rd_en_out is high.
- DISCARD: each bg_valid_in decrements disc without producing output. When the last discard pixel arrives → RUN. Sprite inputs are ignored.
- RUN: on each bg_valid_in:
  - bgc = bg_win_ena_in ? bg_pixel_in : 0
  - spc = sprite_valid_in ? sprite_pixel_in : 0
  - Sprite wins iff spc ≠ 0 && (!sprite_priority_in || bgc == 0).
  - shade = pal[2c+1:2c], where c is the winning colour and pal is OBP0/OBP1 (sprite) or BGP (background).
  - Registers pixel_out, sets pixel_valid_out, X_out = X, then X++.
- When the pixel with X = X_MAX-1 is emitted: line_done_out pulses in the same cycle → DONE.
- IDLE/DONE: bg_valid_in and sprite inputs are ignored; bg_rd_en_out = 0.
- Width rules:
  - X is 8 bits and saturates at X_MAX (never wraps).
  - disc + X_MAX is computed in 9 bits (max 167).

## Timing
- Reset values: bg_rd_en_out=0, pixel_out=0, pixel_valid_out=0, X_out=0, line_done_out=0, state IDLE.
- The first bg_rd_en_out is asserted the cycle after line_start_in (if not stalled).
- Latency: bg_valid_in at cycle t → pixel_valid_out at t+1.
- Unstalled throughput: 1 pixel/cycle; a line takes disc + X_MAX + 2 cycles from line_start_in to line_done_out.
- sprite_detected_in rising at cycle t: bg_rd_en_out is low at t (combinational). The single read issued at t-1 still completes at t and is emitted normally.
- pixel_valid_out is never high for more than X_MAX cycles per line; the issue counter guarantees no over-read.
- Palette writes take effect on the next mixed pixel.
- Asynchronous reset mid-line: all outputs clear immediately; the block waits for line_start_in.

## Test plan
- SCX=0, BGP=0xE4, bg colour = X%4 every cycle, no sprites → 160 pixels, pixel_out = X%4, X_out 0..159; line_done_out on the 160th pixel, 162 cycles after line_start_in.
- SCX=5, bg stream 0,1,2,3,… → first 5 values dropped; X_out=0 shows colour index 5 mapped via BGP; exactly 165 read pulses.
- Sprite colour 2 with OBP1=0x1B, sprite_palette=1, priority=0 over bg colour 3 → shade 1. Priority=1 over bg 3 → BGP shade of 3. Priority=1 over bg 0 → shade 1.
- sprite_detected_in high for 6 cycles at X=40 → bg_rd_en_out low 6 cycles; X_out continues 41.. with no gaps or duplicates; total still 160.
- bg_win_ena_in=0, BGP=0xE4, bg stream nonzero → all pixels shade 0; sprites still drawn.
- line_start_in at X=80, then rst_in asserted at X=30 of the new line → X restarts at 0 after line_start; on reset all outputs are 0, and nothing more is emitted until the next line_start_in.

Source files
------------

// File: rtl/pixel_mixer.sv
// Background/sprite pixel mixer: pulls the background FIFO, drops SCX fine-scroll
// pixels, merges sprites by priority, maps through the DMG palettes and tracks the line.
module pixel_mixer #(
    parameter int X_MAX = 160
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       line_start_in,
    input  logic [7:0] SCX_in,
    input  logic [7:0] BGP_in,
    input  logic [7:0] OBP0_in,
    input  logic [7:0] OBP1_in,
    input  logic       bg_win_ena_in,
    input  logic       sprite_detected_in,
    output logic       bg_rd_en_out,
    input  logic [1:0] bg_pixel_in,
    input  logic       bg_valid_in,
    input  logic [1:0] sprite_pixel_in,
    input  logic       sprite_valid_in,
    input  logic       sprite_palette_in,
    input  logic       sprite_priority_in,
    output logic [1:0] pixel_out,
    output logic       pixel_valid_out,
    output logic [7:0] X_out,
    output logic       line_done_out
);

    typedef enum logic [1:0] {IDLE, DISCARD, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] scx_lat;
    logic [2:0] disc_cnt;
    logic [8:0] issued;
    logic [8:0] issue_lim;
    logic [7:0] x_cnt;
    logic       rd_pending;
    logic       accept;
    logic       vld_p0;
    logic       done_p0;
    logic [1:0] shade_p0;
    logic       scx_unused;

    assign scx_unused = ^SCX_in[7:3];

    function automatic logic [1:0] pal_lookup(input logic [7:0] pal, input logic [1:0] c);
        return pal[{c, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] mix_shade(
        input logic       ena,
        input logic [1:0] bg,
        input logic       spv,
        input logic [1:0] sp,
        input logic       pal_sel,
        input logic       prio,
        input logic [7:0] bgp,
        input logic [7:0] obp0,
        input logic [7:0] obp1
    );
        logic [1:0] bgc;
        logic [1:0] spc;
        bgc = ena ? bg : 2'd0;
        spc = spv ? sp : 2'd0;
        if (spc != 2'd0 && (!prio || bgc == 2'd0))
            return pal_lookup(pal_sel ? obp1 : obp0, spc);
        return pal_lookup(bgp, bgc);
    endfunction

    // A returning read belongs to this line only if it was issued after the last line start.
    assign accept    = bg_valid_in && rd_pending && !line_start_in;
    assign issue_lim = {6'd0, scx_lat} + 9'(X_MAX);
    assign vld_p0    = accept && (state == RUN);
    assign done_p0   = vld_p0 && (x_cnt == 8'(X_MAX - 1));
    assign shade_p0  = mix_shade(bg_win_ena_in, bg_pixel_in, sprite_valid_in, sprite_pixel_in,
                                 sprite_palette_in, sprite_priority_in, BGP_in, OBP0_in, OBP1_in);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (line_start_in) begin
            state_nxt = (SCX_in[2:0] != 3'd0) ? DISCARD : RUN;
        end else begin
            case (state)
                DISCARD: if (accept && disc_cnt == 3'd1) state_nxt = RUN;
                RUN:     if (done_p0)                    state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        bg_rd_en_out = ((state == DISCARD) || (state == RUN)) && !sprite_detected_in
                       && (issued < issue_lim);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            scx_lat    <= 3'd0;
            disc_cnt   <= 3'd0;
            issued     <= 9'd0;
            x_cnt      <= 8'd0;
            rd_pending <= 1'b0;
        end else if (line_start_in) begin
            scx_lat    <= SCX_in[2:0];
            disc_cnt   <= SCX_in[2:0];
            issued     <= 9'd0;
            x_cnt      <= 8'd0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= bg_rd_en_out;
            if (bg_rd_en_out)
                issued <= issued + 9'd1;
            if (accept && state == DISCARD)
                disc_cnt <= disc_cnt - 3'd1;
            if (vld_p0 && x_cnt < 8'(X_MAX))
                x_cnt <= x_cnt + 8'd1;
        end
    end

    // p0 -> output register: shade, coordinate and line-complete pulse
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pixel_out       <= 2'd0;
            pixel_valid_out <= 1'b0;
            X_out           <= 8'd0;
            line_done_out   <= 1'b0;
        end else begin
            pixel_valid_out <= vld_p0;
            line_done_out   <= done_p0;
            if (vld_p0) begin
                pixel_out <= shade_p0;
                X_out     <= x_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Directed bench for pixel_mixer: a FIFO responder feeds per-read vectors, every emitted
// pixel is checked against a hand-computed shade and the expected X sequence.
`timescale 1ns/1ps
module tb_pixel_mixer;

    localparam int X_MAX = 160;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       line_start_in = 1'b0;
    logic [7:0] SCX_in = 8'd0;
    logic [7:0] BGP_in = 8'hE4;
    logic [7:0] OBP0_in = 8'd0;
    logic [7:0] OBP1_in = 8'd0;
    logic       bg_win_ena_in = 1'b1;
    logic       sprite_detected_in = 1'b0;
    logic       bg_rd_en_out;
    logic [1:0] bg_pixel_in = 2'd0;
    logic       bg_valid_in = 1'b0;
    logic [1:0] sprite_pixel_in = 2'd0;
    logic       sprite_valid_in = 1'b0;
    logic       sprite_palette_in = 1'b0;
    logic       sprite_priority_in = 1'b0;
    logic [1:0] pixel_out;
    logic       pixel_valid_out;
    logic [7:0] X_out;
    logic       line_done_out;

    pixel_mixer #(.X_MAX(X_MAX)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .line_start_in(line_start_in), .SCX_in(SCX_in),
        .BGP_in(BGP_in), .OBP0_in(OBP0_in), .OBP1_in(OBP1_in), .bg_win_ena_in(bg_win_ena_in),
        .sprite_detected_in(sprite_detected_in), .bg_rd_en_out(bg_rd_en_out),
        .bg_pixel_in(bg_pixel_in), .bg_valid_in(bg_valid_in), .sprite_pixel_in(sprite_pixel_in),
        .sprite_valid_in(sprite_valid_in), .sprite_palette_in(sprite_palette_in),
        .sprite_priority_in(sprite_priority_in), .pixel_out(pixel_out),
        .pixel_valid_out(pixel_valid_out), .X_out(X_out), .line_done_out(line_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       ena;
        logic [1:0] bg;
        logic       spv;
        logic [1:0] spc;
        logic       pal;
        logic       prio;
        logic [7:0] bgp;
        logic [7:0] obp0;
        logic [7:0] obp1;
        logic [1:0] shade;
    } vec_t;

    vec_t vecs [0:167];
    vec_t mix_tab [0:11];

    int   n_cmp = 0, n_fail = 0;
    int   cur_scx, rd_k, reads, exp_x, ncyc, done_cyc, npix;
    int   stall_at = -1, stall_len = 0, stall_left = 0, stall_done = 0, stall_cyc = 0, stall_bad = 0;
    logic rd_s = 1'b0, stale = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        vec_t v;
        int   idx;
        @(negedge clk_in);
        rd_s  = bg_rd_en_out;
        stale = line_start_in;
        if (rd_s && !stale) reads++;
        if (sprite_detected_in) begin
            stall_cyc++;
            if (rd_s) stall_bad++;
        end
        @(posedge clk_in);
        #1;
        ncyc++;
        if (pixel_valid_out) begin
            check("x_seq", 32'(X_out), exp_x);
            idx = exp_x + cur_scx;
            if (idx > 167) idx = 167;
            check("shade", 32'(pixel_out), 32'(vecs[idx].shade));
            if (stall_at >= 0 && int'(X_out) == stall_at && stall_done == 0) begin
                stall_left = stall_len;
                stall_done = 1;
            end
            exp_x++;
            npix++;
        end
        if (line_done_out) begin
            check("done_x", 32'(X_out), X_MAX - 1);
            check("done_valid", 32'(pixel_valid_out), 1);
            if (done_cyc < 0) done_cyc = ncyc;
        end
        sprite_detected_in = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        bg_valid_in = rd_s;
        if (rd_s && stale) begin
            bg_pixel_in = 2'd3; sprite_valid_in = 1'b1; sprite_pixel_in = 2'd3;
            sprite_priority_in = 1'b0;
        end else if (rd_s) begin
            v = vecs[(rd_k > 167) ? 167 : rd_k];
            rd_k++;
            bg_win_ena_in = v.ena; bg_pixel_in = v.bg; sprite_valid_in = v.spv;
            sprite_pixel_in = v.spc; sprite_palette_in = v.pal; sprite_priority_in = v.prio;
            BGP_in = v.bgp; OBP0_in = v.obp0; OBP1_in = v.obp1;
        end else begin
            bg_pixel_in = 2'd0; sprite_valid_in = 1'b0; sprite_pixel_in = 2'd0;
        end
    endtask

    task automatic start_line(input int scx);
        cur_scx = scx;
        SCX_in = {5'b10101, 3'(scx)};
        rd_k = 0; reads = 0; exp_x = 0; ncyc = 0; done_cyc = -1; npix = 0;
        stall_done = 0; stall_left = 0; stall_cyc = 0; stall_bad = 0;
        line_start_in = 1'b1;
        cycle();
        line_start_in = 1'b0;
    endtask

    task automatic finish_line(input string tag, input int exp_done, input int exp_reads);
        for (int i = 0; i < 400 && done_cyc < 0; i++) cycle();
        repeat (4) cycle();
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_pixels"}, npix, X_MAX);
        check({tag, "_reads"}, reads, exp_reads);
    endtask

    task automatic fill_default();
        for (int k = 0; k < 168; k++)
            vecs[k] = '{1'b1, 2'(k % 4), 1'b0, 2'd0, 1'b0, 1'b0, 8'hE4, 8'h00, 8'h00, 2'(k % 4)};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_out"}, 32'(pixel_out), 0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid_out), 0);
        check({tag, "_X_out"}, 32'(X_out), 0);
        check({tag, "_line_done"}, 32'(line_done_out), 0);
        check({tag, "_rd_en"}, 32'(bg_rd_en_out), 0);
    endtask

    initial begin
        //            ena  bg     spv   spc    pal   prio  BGP    OBP0   OBP1   shade
        mix_tab[0]  = '{1'b1, 2'd3, 1'b1, 2'd2, 1'b1, 1'b0, 8'hE4, 8'h00, 8'h1B, 2'd1};
        mix_tab[1]  = '{1'b1, 2'd3, 1'b1, 2'd2, 1'b1, 1'b1, 8'hE4, 8'h00, 8'h1B, 2'd3};
        mix_tab[2]  = '{1'b1, 2'd0, 1'b1, 2'd2, 1'b1, 1'b1, 8'hE4, 8'h00, 8'h1B, 2'd1};
        mix_tab[3]  = '{1'b1, 2'd2, 1'b0, 2'd3, 1'b0, 1'b0, 8'hE4, 8'hFF, 8'hFF, 2'd2};
        mix_tab[4]  = '{1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 8'hE4, 8'hFF, 8'hFF, 2'd1};
        mix_tab[5]  = '{1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 8'hE4, 8'hFF, 8'hFF, 2'd0};
        mix_tab[6]  = '{1'b0, 2'd3, 1'b1, 2'd1, 1'b0, 1'b1, 8'hE4, 8'hE4, 8'hFF, 2'd1};
        mix_tab[7]  = '{1'b1, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0, 8'hE4, 8'h27, 8'hFF, 2'd0};
        mix_tab[8]  = '{1'b1, 2'd2, 1'b1, 2'd1, 1'b1, 1'b0, 8'hE4, 8'h00, 8'h0C, 2'd3};
        mix_tab[9]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h08, 8'hFF, 8'hFF, 2'd2};
        mix_tab[10] = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 8'h30, 8'hFF, 8'hFF, 2'd3};
        mix_tab[11] = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 1'b1, 8'h40, 8'hFF, 8'hFF, 2'd1};

        #2 rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");
        rst_in = 1'b1;
        cur_scx = 0; exp_x = 0; npix = 0; done_cyc = -1; reads = 0; rd_k = 0; ncyc = 0;
        fill_default();
        repeat (3) cycle();
        check("idle_no_pixels", npix, 0);
        check("idle_no_reads", reads, 0);

        // Plain line, SCX=0, identity palette
        start_line(0);
        finish_line("scx0", 162, 160);

        // Fine scroll of 5: discarded pixels carry sprites that must not appear
        for (int k = 0; k < 168; k++)
            vecs[k] = '{1'b1, 2'(k % 4), (k < 5), 2'd3, 1'b0, 1'b0, 8'h1B, 8'hFF, 8'hFF,
                        2'(3 - (k % 4))};
        start_line(5);
        finish_line("scx5", 167, 165);

        // Mixing table on the first twelve pixels of a line
        fill_default();
        for (int i = 0; i < 12; i++) vecs[i] = mix_tab[i];
        start_line(0);
        finish_line("mix", 162, 160);

        // Sprite-fetch stall of 6 cycles at X=40
        fill_default();
        stall_at = 40; stall_len = 6;
        start_line(0);
        finish_line("stall", 168, 160);
        check("stall_cycles", stall_cyc, 6);
        check("stall_rd_while_stalled", stall_bad, 0);
        stall_at = -1;

        // Background disabled: only sprites (every 10th pixel) show
        for (int k = 0; k < 168; k++)
            vecs[k] = '{1'b0, 2'(1 + k % 3), (k % 10 == 0), 2'd3, 1'b0, 1'((k / 10) % 2),
                        8'hE4, 8'hE4, 8'h00, (k % 10 == 0) ? 2'd3 : 2'd0};
        start_line(0);
        finish_line("bgoff", 162, 160);

        // Abort at X=80 with a new line, then asynchronous reset at X=30
        fill_default();
        start_line(0);
        for (int i = 0; i < 300 && exp_x < 81; i++) cycle();
        check("abort_reached_x80", exp_x, 81);
        start_line(2);
        for (int i = 0; i < 300 && exp_x < 31; i++) cycle();
        check("restart_reached_x30", exp_x, 31);
        #2 rst_in = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        repeat (2) cycle();
        rst_in = 1'b1;
        npix = 0; reads = 0;
        repeat (10) cycle();
        check("post_reset_no_pixels", npix, 0);
        check("post_reset_no_reads", reads, 0);

        start_line(0);
        finish_line("recover", 162, 160);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no summary, expected completion");
        $fatal(1);
    end

endmodule
